// File: rtl/washing_machine_water_fill_controller.sv
// ----------------------------------------------------------------------------
// washing_machine_water_fill_controller
//
// Purpose: sequences the drum water inlet and drain for a washing machine.
// A start request latches the target level and opens the inlet. When the
// target is reached the controller holds it with hysteresis until a drain
// request arrives. Fill and drain are each guarded by a cycle timeout that
// latches a fault until it is acknowledged. Abort forces a drain from FILL
// or HOLD.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   start        in   1   single-cycle fill request (IDLE only)
//   water_level  in  10   target level from load-size detection
//   level_sensor in  10   measured drum level
//   drain        in   1   drain request (HOLD only)
//   abort        in   1   emergency stop, forces DRAIN from FILL/HOLD
//   clear        in   1   fault acknowledge (FAULT only)
//   inlet_valve  out  1   high only in FILL
//   drain_valve  out  1   high only in DRAIN
//   fill_done    out  1   high only in HOLD
//   fault        out  1   high only in FAULT
//   state        out  3   IDLE=0 FILL=1 HOLD=2 DRAIN=3 FAULT=4
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | valves closed, waiting for start with a non-zero level
// FILL  | inlet open until level_sensor >= target or fill timeout
// HOLD  | target reached; refill on sag past HYST, drain on request
// DRAIN | drain open until drum empty or drain timeout
// FAULT | timeout latched, valves closed, waiting for clear
// ----------------------------------------------------------------------------
module washing_machine_water_fill_controller #(
    parameter int FILL_TIMEOUT  = 600,
    parameter int DRAIN_TIMEOUT = 600,
    parameter int HYST          = 5,
    parameter int EMPTY_LEVEL   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] water_level,
    input  logic [9:0] level_sensor,
    input  logic       drain,
    input  logic       abort,
    input  logic       clear,
    output logic       inlet_valve,
    output logic       drain_valve,
    output logic       fill_done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic [9:0]  r_target;
    logic [15:0] r_counter;

    state_t      w_next;
    logic [9:0]  w_target_next;
    logic [15:0] w_counter_next;
    logic [10:0] w_sag_sum;
    logic        w_target_met;
    logic        w_empty;
    logic        w_fill_to;
    logic        w_drain_to;

    // Sensor plus hysteresis in 11 bits so a high reading cannot wrap below target.
    assign w_sag_sum    = {1'b0, level_sensor} + 11'(HYST);
    assign w_target_met = (level_sensor >= r_target);
    assign w_empty      = (level_sensor <= 10'(EMPTY_LEVEL));
    assign w_fill_to    = (r_counter == 16'(FILL_TIMEOUT - 1));
    assign w_drain_to   = (r_counter == 16'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_target  <= 10'd0;
            r_counter <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_target  <= w_target_next;
            r_counter <= w_counter_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_target_next  = r_target;
        w_counter_next = r_counter;

        case (r_state)
            S_IDLE: begin
                if (start && (water_level != 10'd0)) begin
                    w_next        = S_FILL;
                    w_target_next = water_level;
                end
            end
            S_FILL: begin
                if (abort)             w_next = S_DRAIN;
                else if (w_target_met) w_next = S_HOLD;
                else if (w_fill_to)    w_next = S_FAULT;
            end
            S_HOLD: begin
                if (abort)                          w_next = S_DRAIN;
                else if (drain)                     w_next = S_DRAIN;
                else if (w_sag_sum < {1'b0, r_target}) w_next = S_FILL;
            end
            S_DRAIN: begin
                if (w_empty)         w_next = S_IDLE;
                else if (w_drain_to) w_next = S_FAULT;
            end
            S_FAULT: begin
                if (clear) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Counter restarts on every entry to a timed state and runs while staying there.
        if (w_next != r_state) begin
            if ((w_next == S_FILL) || (w_next == S_DRAIN)) w_counter_next = 16'd0;
            if (w_next == S_IDLE)                          w_target_next  = 10'd0;
        end else if ((r_state == S_FILL) || (r_state == S_DRAIN)) begin
            w_counter_next = r_counter + 16'd1;
        end
    end

    // Moore outputs straight from the state register, so async reset closes valves at once.
    assign inlet_valve = (r_state == S_FILL);
    assign drain_valve = (r_state == S_DRAIN);
    assign fill_done   = (r_state == S_HOLD);
    assign fault       = (r_state == S_FAULT);
    assign state       = r_state;

endmodule

// File: tb/tb_washing_machine_water_fill_controller.sv
module tb_washing_machine_water_fill_controller;

    localparam int FT    = 8;
    localparam int DT    = 10;
    localparam int HYSTP = 5;
    localparam int EMPTY = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] water_level = 10'd0;
    logic [9:0] level_sensor = 10'd0;
    logic       drain = 1'b0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic       inlet_valve, drain_valve, fill_done, fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    washing_machine_water_fill_controller #(
        .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT), .HYST(HYSTP), .EMPTY_LEVEL(EMPTY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .water_level(water_level),
        .level_sensor(level_sensor), .drain(drain), .abort(abort), .clear(clear),
        .inlet_valve(inlet_valve), .drain_valve(drain_valve), .fill_done(fill_done),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: state code, target, and cycles already spent in the current state.
    int m_state  = 0;
    int m_target = 0;
    int m_cycles = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_target = 0; m_cycles = 0;
        end else begin
            int lvl;
            lvl = int'(level_sensor);
            case (m_state)
                0: if (start && water_level != 0) begin
                       m_target = int'(water_level); m_state = 1; m_cycles = 0;
                   end
                1: if (abort)                  begin m_state = 3; m_cycles = 0; end
                   else if (lvl >= m_target)   m_state = 2;
                   else if (m_cycles == FT-1)  m_state = 4;
                   else                        m_cycles++;
                2: if (abort || drain)              begin m_state = 3; m_cycles = 0; end
                   else if (lvl + HYSTP < m_target) begin m_state = 1; m_cycles = 0; end
                3: if (lvl <= EMPTY)           begin m_state = 0; m_target = 0; end
                   else if (m_cycles == DT-1)  m_state = 4;
                   else                        m_cycles++;
                4: if (clear)                  begin m_state = 0; m_target = 0; end
                default: m_state = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_state", int'(state), m_state);
            chk("model_inlet", int'(inlet_valve), int'(m_state == 1));
            chk("model_drainv", int'(drain_valve), int'(m_state == 3));
            chk("model_done", int'(fill_done), int'(m_state == 2));
            chk("model_fault", int'(fault), int'(m_state == 4));
            chk("model_target", int'(dut.r_target), m_target);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input int lvl);
        water_level = 10'(lvl);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({inlet_valve, drain_valve, fill_done, fault}), 0);
        reset = 1'b1;
        run_cmp = 1'b1;
        tick();

        // start with zero level ignored; stray drain/abort/clear in IDLE ignored
        pulse_start(0);
        chk("start_zero_idle", int'(state), 0);
        drain = 1; abort = 1; clear = 1; tick(); drain = 0; abort = 0; clear = 0;
        chk("idle_ignores", int'(state), 0);

        // normal fill to 300
        level_sensor = 0;
        pulse_start(300);
        chk("fill_inlet", int'(inlet_valve), 1);
        water_level = 10'd50;
        level_sensor = 100; tick();
        level_sensor = 200; tick();
        start = 1; tick(); start = 0;
        chk("start_ignored_fill", int'(state), 1);
        level_sensor = 300; tick();
        chk("hold_state", int'(state), 2);
        chk("hold_done", int'(fill_done), 1);
        chk("hold_target", int'(dut.r_target), 300);

        // hysteresis
        level_sensor = 295; ticks(3);
        chk("hyst_295_hold", int'(state), 2);
        level_sensor = 294; tick();
        chk("hyst_294_fill", int'(inlet_valve), 1);
        level_sensor = 300; tick();
        chk("refill_hold", int'(state), 2);

        // drain then empty
        drain = 1; tick(); drain = 0;
        chk("drain_valve", int'(drain_valve), 1);
        abort = 1; tick(); abort = 0;
        chk("abort_in_drain", int'(state), 3);
        level_sensor = 0; tick();
        chk("drain_idle", int'(state), 0);
        chk("drain_target0", int'(dut.r_target), 0);

        // abort during fill
        level_sensor = 50;
        pulse_start(200);
        drain = 1; tick(); drain = 0;
        chk("drain_ign_fill", int'(state), 1);
        abort = 1; tick(); abort = 0;
        chk("abort_drain", int'(drain_valve), 1);
        level_sensor = 0; tick();
        chk("abort_idle", int'(state), 0);

        // fill timeout
        level_sensor = 0;
        pulse_start(100);
        n = 0;
        while (state == 3'd1 && n < 50) begin n++; tick(); end
        chk("fill_cycles", n, FT);
        chk("timeout_fault", int'(fault), 1);
        chk("fault_valves", int'({inlet_valve, drain_valve}), 0);
        abort = 1; drain = 1; start = 1; tick(); abort = 0; drain = 0; start = 0;
        chk("fault_held", int'(state), 4);
        clear = 1; tick(); clear = 0;
        chk("clear_idle", int'(state), 0);

        // target met on the last allowed fill cycle: HOLD wins
        level_sensor = 0;
        pulse_start(100);
        ticks(FT - 1);
        chk("prio_still_fill", int'(state), 1);
        level_sensor = 100; tick();
        chk("prio_hold", int'(state), 2);

        // drain timeout
        drain = 1; tick(); drain = 0;
        n = 0;
        while (state == 3'd3 && n < 50) begin n++; tick(); end
        chk("drain_cycles", n, DT);
        chk("drain_to_fault", int'(fault), 1);
        clear = 1; tick(); clear = 0;

        // async reset mid-fill, between edges
        level_sensor = 0;
        pulse_start(400);
        tick();
        chk("pre_reset_fill", int'(inlet_valve), 1);
        reset = 1'b0;
        #1;
        chk("async_inlet", int'(inlet_valve), 0);
        chk("async_state", int'(state), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_idle", int'(state), 0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
